// File: rtl/seq_signed_multiplier.sv
// Sequential shift-and-add multiplier: signed BW_MCAND multiplicand times unsigned BW_MPLIER multiplier.
// Latency: Start sampled at edge T0 -> Prod valid with a one-cycle Done pulse after edge T0+BW_MPLIER+2.
// Backpressure: none; Start is accepted in any state and aborts an operation in flight without a Done pulse.
//
// Ports:
//   Clock  - rising-edge clock
//   Reset  - asynchronous, active-high; clears every register and returns to IDLE
//   Start  - begin an operation; Mcand/Mplier are captured on the same edge
//   Mcand  - signed two's-complement multiplicand (BW_MCAND bits)
//   Mplier - unsigned multiplier (BW_MPLIER bits)
//   Prod   - signed two's-complement product; held until the next completed operation
//   Busy   - high while an operation is in progress
//   Done   - one-cycle pulse on the cycle Prod is updated
//
// BW_I must be wide enough that 2**BW_I > BW_MPLIER so the iteration count fits.

module seq_signed_multiplier #(
    parameter int BW_MCAND  = 8,
    parameter int BW_MPLIER = 4,
    parameter int BW_I      = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic [BW_MCAND-1:0]           Mcand,
    input  logic [BW_MPLIER-1:0]          Mplier,
    output logic [BW_MCAND+BW_MPLIER-1:0] Prod,
    output logic                          Busy,
    output logic                          Done
);

    localparam int BW_PROD = BW_MCAND + BW_MPLIER;
    // Shift register layout: {carry, accumulator[BW_MCAND], multiplier[BW_MPLIER]}
    localparam int BW_SH   = 1 + BW_MCAND + BW_MPLIER;

    localparam logic [BW_MCAND-1:0] ONE_MCAND = BW_MCAND'(1);
    localparam logic [BW_PROD-1:0]  ONE_PROD  = BW_PROD'(1);
    localparam logic [BW_I-1:0]     ONE_I     = BW_I'(1);
    localparam logic [BW_I-1:0]     ITER_INIT = BW_I'(BW_MPLIER);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CONV = 3'd2,
        LOOP = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Operand / working registers
    logic [BW_MCAND-1:0] mcand_q;   // captured signed multiplicand
    logic [BW_MCAND-1:0] mag_q;     // |Mcand| as an unsigned value
    logic                sign_q;    // sign of the captured multiplicand
    logic [BW_SH-1:0]    shreg_q;   // {carry, acc, mplier}
    logic [BW_I-1:0]     i_q;       // remaining LOOP iterations

    // Combinational helpers
    logic [BW_MCAND-1:0] mag_conv;
    logic [BW_MCAND:0]   upper;
    logic [BW_MCAND:0]   upper_sum;
    logic [BW_MCAND:0]   upper_sel;
    logic [BW_SH-1:0]    shreg_nxt;
    logic [BW_PROD-1:0]  prod_mag;
    logic [BW_PROD-1:0]  prod_fin;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Start has priority over every state so that a new
    // request aborts whatever is in flight, including the FIN cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (Start) begin
            state_nxt = CONV;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                // LOAD is never entered from Start (capture happens on the
                // Start edge itself); it simply falls through if reached.
                LOAD:    state_nxt = CONV;
                CONV:    state_nxt = LOOP;
                // Leave after the iteration with i==1; i==0 guards a
                // corrupted counter from looping forever.
                LOOP:    state_nxt = (i_q <= ONE_I) ? FIN : LOOP;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        // Two's-complement negation only for negative operands. The most
        // negative value maps onto itself, which read as unsigned is the
        // correct magnitude 2**(BW_MCAND-1).
        mag_conv = mcand_q;
        if (mcand_q[BW_MCAND-1]) begin
            mag_conv = ~mcand_q + ONE_MCAND;
        end

        // Conditional add into the upper half (carry + accumulator). The
        // carry bit is always zero here because the previous shift moved it
        // down into the accumulator MSB.
        upper     = shreg_q[BW_SH-1:BW_MPLIER];
        upper_sum = upper + {1'b0, mag_q};
        upper_sel = shreg_q[0] ? upper_sum : upper;
        shreg_nxt = {upper_sel, shreg_q[BW_MPLIER-1:0]} >> 1;

        // After BW_MPLIER shifts the full unsigned product sits in the low
        // BW_PROD bits; the magnitude bound guarantees the negation fits.
        prod_mag = shreg_q[BW_PROD-1:0];
        prod_fin = prod_mag;
        if (sign_q) begin
            prod_fin = ~prod_mag + ONE_PROD;
        end
    end

    // ------------------------------------------------------------------
    // Working registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mcand_q <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            shreg_q <= '0;
            i_q     <= '0;
        end else if (Start) begin
            mcand_q <= Mcand;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            shreg_q <= {{(1 + BW_MCAND){1'b0}}, Mplier};
            i_q     <= ITER_INIT;
        end else begin
            case (state)
                CONV: begin
                    mag_q  <= mag_conv;
                    sign_q <= mcand_q[BW_MCAND-1];
                end
                LOOP: begin
                    if (i_q != '0) begin
                        shreg_q <= shreg_nxt;
                        i_q     <= i_q - ONE_I;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Prod only moves in FIN, so an aborted operation never
    // exposes a partial or stale result.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Prod <= '0;
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Start) begin
                Busy <= 1'b1;
            end else if (state == FIN) begin
                Prod <= prod_fin;
                Busy <= 1'b0;
                Done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
module tb_seq_signed_multiplier;

    localparam int BW_MCAND  = 8;
    localparam int BW_MPLIER = 4;
    localparam int BW_I      = 4;
    localparam int PW        = BW_MCAND + BW_MPLIER;
    localparam int LAT       = BW_MPLIER + 2;

    logic                 Clock  = 1'b0;
    logic                 Reset  = 1'b1;
    logic                 Start  = 1'b0;
    logic [BW_MCAND-1:0]  Mcand  = '0;
    logic [BW_MPLIER-1:0] Mplier = '0;
    logic [PW-1:0]        Prod;
    logic                 Busy;
    logic                 Done;

    int errors = 0;
    int checks = 0;

    seq_signed_multiplier #(
        .BW_MCAND (BW_MCAND),
        .BW_MPLIER(BW_MPLIER),
        .BW_I     (BW_I)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .Mcand (Mcand),
        .Mplier(Mplier),
        .Prod  (Prod),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference product: plain signed-times-unsigned arithmetic, truncated to
    // the product width.
    function automatic logic [PW-1:0] ref_prod(input logic [BW_MCAND-1:0] a,
                                               input logic [BW_MPLIER-1:0] b);
        int sa;
        int ub;
        sa = int'($signed(a));
        ub = int'(b);
        return PW'(sa * ub);
    endfunction

    // Behavioural model: an accepted Start schedules a result LAT edges later;
    // a newer Start or a reset cancels it.
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic          m_pend = 1'b0;
    int            m_left = 0;
    logic [PW-1:0] m_prod = '0;
    logic [PW-1:0] m_exp  = '0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_pend <= 1'b0;
            m_left <= 0;
            m_prod <= '0;
        end else begin
            m_done <= 1'b0;
            if (Start) begin
                m_busy <= 1'b1;
                m_pend <= 1'b1;
                m_left <= LAT;
                m_exp  <= ref_prod(Mcand, Mplier);
            end else if (m_pend) begin
                if (m_left == 1) begin
                    m_prod <= m_exp;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_pend <= 1'b0;
                end
                m_left <= m_left - 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        chk("cyc_busy", int'(Busy), int'(m_busy));
        chk("cyc_done", int'(Done), int'(m_done));
        chk("cyc_prod", int'(Prod), int'(m_prod));
    end

    // Run one operation from Start to Done and pin the result to a literal.
    task automatic run_op(input string nm, input logic [BW_MCAND-1:0] mc,
                          input logic [BW_MPLIER-1:0] mp, input logic [PW-1:0] exp);
        int n;
        int busy_cnt;
        @(negedge Clock);
        Start  = 1'b1;
        Mcand  = mc;
        Mplier = mp;
        @(negedge Clock);
        Start  = 1'b0;
        chk({nm, "_done_after_start"}, int'(Done), 0);
        n = 0;
        busy_cnt = 0;
        while (!Done && n < 4 * LAT) begin
            if (Busy) busy_cnt++;
            Mcand  = BW_MCAND'($urandom);
            Mplier = BW_MPLIER'($urandom);
            @(negedge Clock);
            n++;
        end
        chk({nm, "_latency"}, n, LAT);
        chk({nm, "_prod"}, int'(Prod), int'(exp));
        chk({nm, "_busy_low"}, int'(Busy), 0);
        chk({nm, "_busy_cycles"}, busy_cnt, LAT);
        @(negedge Clock);
        chk({nm, "_done_one_cycle"}, int'(Done), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int done_cnt;
        int seen_stale;

        #1;
        chk("reset_prod", int'(Prod), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_done", int'(Done), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        chk("idle_after_reset", int'(Busy), 0);

        // Directed cases with hand-computed products
        run_op("p05x3", 8'h05, 4'h3, 12'h00F);
        run_op("pFDx5", 8'hFD, 4'h5, 12'hFF1);
        run_op("p80xF", 8'h80, 4'hF, 12'h880);
        run_op("p7FxF", 8'h7F, 4'hF, 12'h771);
        run_op("pF0x0", 8'hF0, 4'h0, 12'h000);
        run_op("p80x0", 8'h80, 4'h0, 12'h000);

        // Abort: second Start two cycles after the first
        @(negedge Clock);
        Start = 1'b1; Mcand = 8'h05; Mplier = 4'h3;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        Start = 1'b1; Mcand = 8'h02; Mplier = 4'h4;
        @(negedge Clock);
        Start = 1'b0;
        n = 0;
        done_cnt = 0;
        seen_stale = 0;
        while (!Done && n < 4 * LAT) begin
            if (Prod == 12'h00F) seen_stale = 1;
            @(negedge Clock);
            n++;
        end
        chk("abort_latency", n, LAT);
        chk("abort_prod", int'(Prod), 12'h008);
        repeat (10) begin
            if (Done) done_cnt++;
            if (Prod == 12'h00F) seen_stale = 1;
            @(negedge Clock);
        end
        chk("abort_done_pulses", done_cnt, 1);
        chk("abort_no_stale", seen_stale, 0);

        // Reset in the middle of LOOP
        @(negedge Clock);
        Start = 1'b1; Mcand = 8'h7F; Mplier = 4'hF;
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_prod", int'(Prod), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_done", int'(Done), 0);
        @(negedge Clock);
        Reset = 1'b0;
        done_cnt = 0;
        repeat (12) begin
            @(negedge Clock);
            if (Done || Busy) done_cnt++;
        end
        chk("midrst_stays_idle", done_cnt, 0);

        // Randomized traffic: frequent aborts, occasional resets and extremes
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clock);
            Reset  = 1'b0;
            Start  = ($urandom_range(0, 9) == 0);
            Mcand  = BW_MCAND'($urandom);
            Mplier = BW_MPLIER'($urandom);
            if ($urandom_range(0, 7) == 0) Mcand = 8'h80;
            if ($urandom_range(0, 7) == 0) Mplier = 4'hF;
            if ($urandom_range(0, 249) == 0) begin
                #2 Reset = 1'b1;
            end
        end
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        repeat (2 * LAT) @(negedge Clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
